// File: rtl/count_pkg.sv
// Shared definitions for the up/down counter family.
// Holds the counting-mode constants and a width helper so every counter
// derives its register widths the same way.
package count_pkg;

    // Behaviour of a counter that steps while sitting at its terminal value.
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Number of bits needed to hold any value in 0..maxVal (never less than 1).
    function automatic int cnt_bits(input int unsigned maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/up_count_prescale.sv
// Enable prescaler for up_count.
// Passes one step through for every PRESCALE enabled cycles.
// The phase holds while en is low and returns to zero on clr or reset.
module up_count_prescale
    import count_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int            PW   = cnt_bits(PRESCALE - 1);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // Advance the phase on enabled cycles and restart it after the last phase.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // Phase register, asynchronously cleared by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign step = en && (presc_q == LAST);

endmodule

// File: rtl/up_count.sv
// Modulo-(MAX+1) up counter with enable, synchronous clear/load,
// one-cycle terminal-count pulse and a sticky overflow flag.
// Define UP_COUNT_PRESCALE_EN to divide the enable by PRESCALE; otherwise
// every enabled cycle steps and PRESCALE is ignored.
module up_count
    import count_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SATURATE = CNT_WRAP,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] no,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             step;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

`ifdef UP_COUNT_PRESCALE_EN
    // The prescaler only sees cycles that would really step, so a load
    // leaves its phase untouched and clr restarts it.
    up_count_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en & ~load & ~clr),
        .step (step)
    );
`else
    assign step = en;

    // Without the prescaler PRESCALE has no effect; this block only keeps
    // the parameter referenced in that build.
    if (PRESCALE < 2) begin : g_prescaleUnused
    end
`endif

    // Next count and flags: clr beats load, load beats a step, else hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            if (load_val <= MAX_V) begin
                count_d = load_val;
            end else begin
                count_d = MAX_V;
                ovf_d   = 1'b1;
            end
        end else if (step) begin
            if (count_q == MAX_V) begin
                tc_d = 1'b1;
                if (SATURATE == CNT_SAT) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count and flag registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign no  = count_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_up_count.sv
// Directed testbench for up_count: three instances (2-bit wrap, 2-bit
// saturate, 3-bit modulo-6) share one stimulus stream. Built with
// UP_COUNT_PRESCALE_EN it checks the prescaled stepping instead.
module tb_up_count;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       load;
    logic [2:0] loadVal;

    logic [1:0] noWrap;
    logic       tcWrap;
    logic       ovfWrap;
    logic [1:0] noSat;
    logic       tcSat;
    logic       ovfSat;
    logic [2:0] noMod;
    logic       tcMod;
    logic       ovfMod;

    int compared   = 0;
    int mismatched = 0;

    up_count #(.WIDTH(2)) dWrap (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(loadVal[1:0]), .no(noWrap), .tc(tcWrap), .ovf(ovfWrap)
    );

    up_count #(.WIDTH(2), .SATURATE(1)) dSat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(loadVal[1:0]), .no(noSat), .tc(tcSat), .ovf(ovfSat)
    );

    up_count #(.WIDTH(3), .MAX(5)) dMod (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
        .load_val(loadVal), .no(noMod), .tc(tcMod), .ovf(ovfMod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic c, input logic l, input logic [2:0] v);
        en      = e;
        clr     = c;
        load    = l;
        loadVal = v;
    endtask

`ifdef UP_COUNT_PRESCALE_EN
    int enPat [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
    int expP  [14] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3};
`else
    int wrapExp [7] = '{1, 2, 3, 0, 1, 2, 3};
    int wrapTc  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int satExp  [7] = '{1, 2, 3, 3, 3, 3, 3};
    int satTc   [7] = '{0, 0, 0, 1, 1, 1, 1};
    int satOvf  [7] = '{0, 0, 0, 1, 1, 1, 1};
    int modExp  [7] = '{1, 2, 3, 4, 5, 0, 1};
    int modTc   [7] = '{0, 0, 0, 0, 0, 1, 0};
`endif

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        #6;
        checkOutput("reset_no_wrap", 32'(noWrap), 0);
        checkOutput("reset_tc_wrap", 32'(tcWrap), 0);
        checkOutput("reset_ovf_sat", 32'(ovfSat), 0);
        checkOutput("reset_no_mod", 32'(noMod), 0);
        #6;
        rst = 1'b1;

`ifdef UP_COUNT_PRESCALE_EN
        for (int i = 0; i < 14; i++) begin
            en = enPat[i][0];
            tick();
            checkOutput($sformatf("presc_no_%0d", i), 32'(noWrap), 32'(expP[i]));
        end
`else
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput($sformatf("wrap_no_%0d", i), 32'(noWrap), 32'(wrapExp[i]));
            checkOutput($sformatf("wrap_tc_%0d", i), 32'(tcWrap), 32'(wrapTc[i]));
            checkOutput($sformatf("wrap_ovf_%0d", i), 32'(ovfWrap), 0);
            checkOutput($sformatf("sat_no_%0d", i), 32'(noSat), 32'(satExp[i]));
            checkOutput($sformatf("sat_tc_%0d", i), 32'(tcSat), 32'(satTc[i]));
            checkOutput($sformatf("sat_ovf_%0d", i), 32'(ovfSat), 32'(satOvf[i]));
            checkOutput($sformatf("mod_no_%0d", i), 32'(noMod), 32'(modExp[i]));
            checkOutput($sformatf("mod_tc_%0d", i), 32'(tcMod), 32'(modTc[i]));
        end

        // Hold: count frozen, tc drops, sticky ovf survives.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("hold_no_wrap", 32'(noWrap), 3);
        checkOutput("hold_tc_sat", 32'(tcSat), 0);
        checkOutput("hold_ovf_sat", 32'(ovfSat), 1);
        checkOutput("hold_no_mod", 32'(noMod), 1);

        // Out-of-range load clamps to MAX and flags overflow.
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd7);
        tick();
        checkOutput("load7_no_mod", 32'(noMod), 5);
        checkOutput("load7_ovf_mod", 32'(ovfMod), 1);
        checkOutput("load7_tc_mod", 32'(tcMod), 0);

        // Load beats enable.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
        tick();
        checkOutput("ldEn_no_mod", 32'(noMod), 2);
        checkOutput("ldEn_no_wrap", 32'(noWrap), 2);
        checkOutput("ldEn_ovf_mod", 32'(ovfMod), 1);

        // Clear beats load and enable, and drops the sticky flags.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd1);
        tick();
        checkOutput("clr_no_mod", 32'(noMod), 0);
        checkOutput("clr_no_sat", 32'(noSat), 0);
        checkOutput("clr_tc_mod", 32'(tcMod), 0);
        checkOutput("clr_ovf_mod", 32'(ovfMod), 0);
        checkOutput("clr_ovf_sat", 32'(ovfSat), 0);

        // Count to 2, then reset between edges.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        tick();
        checkOutput("pre_rst_no_wrap", 32'(noWrap), 2);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_no_wrap", 32'(noWrap), 0);
        checkOutput("async_rst_tc_wrap", 32'(tcWrap), 0);
        checkOutput("async_rst_no_mod", 32'(noMod), 0);
        tick();
        checkOutput("rst_held_no_wrap", 32'(noWrap), 0);
        #3;
        rst = 1'b1;
        tick();
        checkOutput("restart_no_wrap", 32'(noWrap), 1);
        checkOutput("restart_no_mod", 32'(noMod), 1);

        // Loading exactly MAX is in range: no overflow.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd5);
        tick();
        checkOutput("loadMax_no_mod", 32'(noMod), 5);
        checkOutput("loadMax_ovf_mod", 32'(ovfMod), 0);

        // Step from MAX wraps with a tc pulse and no overflow.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("wrapMax_no_mod", 32'(noMod), 0);
        checkOutput("wrapMax_tc_mod", 32'(tcMod), 1);
        checkOutput("wrapMax_ovf_mod", 32'(ovfMod), 0);
        tick();
        checkOutput("tcOnce_tc_mod", 32'(tcMod), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
